// File: rtl/qdi_e1of4_register_responder_pkg.sv
// Shared types and rail-coding helpers for the e1of4 register responder.
package qdi_resp_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_WRRD  = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ACCEPT,
    RTZ,
    OUT_WAIT,
    OUT_DRV
  } state_e;

  // Exactly one rail high.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // All rails low.
  function automatic logic is_neutral(input logic [3:0] v);
    return v == 4'b0000;
  endfunction

  // Binary value to 1of4 rails.
  function automatic logic [3:0] enc1of4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  // 1of4 rails to binary value; callers only pass valid codes.
  function automatic logic [1:0] dec1of4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[1]) r = 2'd1;
    if (v[2]) r = 2'd2;
    if (v[3]) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/qdi_e1of4_register_responder_sync.sv
// Flop chain synchronizer for a bus of asynchronous rails.
module qdi_sync_bus #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the raw rails through DEPTH flops; the last flop is the safe copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/qdi_e1of4_register_responder.sv
// e1of4 register responder: accepts 1of3 control and 1of4 data tokens,
// holds a 2-bit register and returns 1of4 read tokens.
// Optional feature macro: QDI_RESP_SYNC_EN (synchronize C, D and Qe through
// SYNC_STAGES flops before any decision uses them).
module qdi_e1of4_register_responder
  import qdi_resp_pkg::*;
#(
  parameter logic [1:0] INIT_VAL    = 2'b00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] C,
  output logic       Ce,
  input  logic [3:0] D,
  output logic       De,
  output logic [3:0] Q,
  input  logic       Qe,
  output logic       err
);

  // Only depths 2..4 are meaningful; out-of-range values leave this marker.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_stages_out_of_range
  end

  logic [2:0] c_s;
  logic [3:0] d_s;
  logic       qe_s;

`ifdef QDI_RESP_SYNC_EN
  qdi_sync_bus #(.WIDTH(3), .DEPTH(SYNC_STAGES)) u_sync_c (
    .clk(CLK), .rst(RESET), .d(C), .q(c_s)
  );
  qdi_sync_bus #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync_d (
    .clk(CLK), .rst(RESET), .d(D), .q(d_s)
  );
  qdi_sync_bus #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_qe (
    .clk(CLK), .rst(RESET), .d(Qe), .q(qe_s)
  );
`else
  assign c_s  = C;
  assign d_s  = D;
  assign qe_s = Qe;
`endif

  state_e     state;
  op_e        op;
  logic       ctl_cap;
  logic       dat_cap;
  logic [1:0] data_val;
  logic [1:0] reg_val;
  logic [1:0] out_val;

  logic c_valid, c_multi, d_valid, d_multi;
  logic ctl_take, ctl_now, dat_take, dat_now;
  logic accept_done, rtz_done;
  op_e  c_op, op_now;

  // Classify the observed rails and decide what ACCEPT captures this cycle.
  always_comb begin
    c_valid     = is_onehot({1'b0, c_s});
    c_multi     = !c_valid && !is_neutral({1'b0, c_s});
    d_valid     = is_onehot(d_s);
    d_multi     = !d_valid && !is_neutral(d_s);
    c_op        = c_s[1] ? OP_WRITE : (c_s[2] ? OP_WRRD : OP_READ);
    ctl_take    = !ctl_cap && c_valid;
    ctl_now     = ctl_cap || ctl_take;
    op_now      = ctl_cap ? op : c_op;
    dat_take    = ctl_now && !dat_cap && d_valid && (op_now != OP_READ);
    dat_now     = dat_cap || dat_take;
    accept_done = ctl_now && ((op_now == OP_READ) || dat_now);
    rtz_done    = is_neutral({1'b0, c_s}) && (!dat_cap || is_neutral(d_s));
  end

  // Token handshake FSM with registered enables, read rails and error flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ACCEPT;
      op       <= OP_READ;
      ctl_cap  <= 1'b0;
      dat_cap  <= 1'b0;
      data_val <= 2'd0;
      reg_val  <= INIT_VAL;
      out_val  <= 2'd0;
      Ce       <= 1'b1;
      De       <= 1'b1;
      Q        <= 4'b0000;
      err      <= 1'b0;
    end else begin
      if (c_multi || (d_multi && state == ACCEPT)) err <= 1'b1;
      case (state)
        ACCEPT: begin
          if (ctl_take) begin
            op      <= c_op;
            ctl_cap <= 1'b1;
            Ce      <= 1'b0;
          end
          if (dat_take) begin
            data_val <= dec1of4(d_s);
            dat_cap  <= 1'b1;
            De       <= 1'b0;
          end
          if (accept_done) state <= RTZ;
        end
        RTZ: begin
          if (rtz_done) begin
            out_val <= reg_val;
            if (op != OP_READ) reg_val <= data_val;
            if (op == OP_WRITE) begin
              state   <= ACCEPT;
              Ce      <= 1'b1;
              De      <= 1'b1;
              ctl_cap <= 1'b0;
              dat_cap <= 1'b0;
            end else begin
              state <= OUT_WAIT;
            end
          end
        end
        OUT_WAIT: begin
          Q <= 4'b0000;
          if (qe_s) begin
            Q     <= enc1of4(out_val);
            state <= OUT_DRV;
          end
        end
        OUT_DRV: begin
          if (!qe_s) begin
            Q       <= 4'b0000;
            Ce      <= 1'b1;
            De      <= 1'b1;
            ctl_cap <= 1'b0;
            dat_cap <= 1'b0;
            state   <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: doc/qdi_e1of4_register_responder.md
Name: qdi_e1of4_register_responder

Overview:
- Clocked responder for the e1of4 register channel protocol. It is the register end facing a token source/sink bench.
- Consumes a 1of3 control token and, when the op needs it, a 1of4 data token, each with its own active-high enable. It produces 1of4 read tokens on an output channel with an active-high enable.
- Holds one 2-bit register value.
- Acts as a synthesizable golden model of the e1of4 register and as the responder that receiver/transmitter benches close the loop against.

Parameters:
- INIT_VAL, 2'b00, register contents after reset.
- SYNC_STAGES, 2, synchronizer depth on C, D and Qe. Used only when QDI_RESP_SYNC_EN is defined; legal range 2..4.

Ports:
- CLK  input  1  clock.
- RESET  input  1  asynchronous, active-high reset.
- C  input  3  1of3 control rails. Rail 0 = READ, rail 1 = WRITE, rail 2 = WRITE_READ.
- Ce  output  1  control enable; high means ready for a control token.
- D  input  4  1of4 data rails; rail k carries value k.
- De  output  1  data enable.
- Q  output  4  1of4 read-data rails.
- Qe  input  1  read-channel enable from the sink.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset values: Ce=1, De=1, Q=4'b0000, err=0, reg=INIT_VAL, state=ACCEPT. All outputs are registered.
- Valid code: exactly one rail high. Neutral: all rails low. Multi-hot: two or more rails high.
- Multi-hot on C or D sets err. That channel is treated as not valid, and err stays set until RESET.
- State ACCEPT:
  - Ce=1 until control is captured; De=1.
  - A valid C latches op and drives Ce=0 next cycle.
  - A valid D is captured only if op (latched this or an earlier cycle) is WRITE or WRITE_READ. Capture latches data and drives De=0 next cycle.
  - Data arriving before the control token is not acknowledged; the sender must hold it.
  - Exit to RTZ when control is captured and (op==READ or data is captured).
- State RTZ:
  - Waits until C is neutral and, if data was captured, D is neutral.
  - On exit, for WRITE or WRITE_READ: old value is saved to out_val, then reg <= data.
  - READ sets out_val=reg.
  - WRITE goes to ACCEPT, with Ce and De re-raised next cycle. The other ops go to OUT_WAIT.
- For READ ops De stays 1 throughout. D is ignored until the next ACCEPT.
- WRITE_READ returns the pre-write value (swap semantics). A following READ returns the new value.
- State OUT_WAIT: Q=0; waits for Qe=1, then drives Q=onehot(out_val) next cycle and moves to OUT_DRV.
- State OUT_DRV: holds Q; on Qe=0, Q<=0 next cycle, then goes to ACCEPT.
- Minimum cycles per WRITE token without sync: 1 (capture) + 1 (RTZ detect) + 1 (re-enable) = 3.
- Simultaneous arrival of C and D in one cycle is legal; both are captured that cycle.
- RESET mid-token aborts immediately to reset values. The in-flight token is lost and reg returns to INIT_VAL.

Optional Feature:
- Macro: QDI_RESP_SYNC_EN.
- Defined: C, D and Qe each pass through a SYNC_STAGES flop chain. All decisions use the synchronized values, adding SYNC_STAGES cycles of latency to every input observation.
- Undefined: inputs are sampled directly. This mode is for same-clock-domain benches only.

Decomposition:
- Package qdi_resp_pkg holds:
  - op enum OP_READ=0, OP_WRITE=1, OP_WRRD=2;
  - state enum ACCEPT, RTZ, OUT_WAIT, OUT_DRV;
  - functions is_onehot, is_neutral, enc1of4 (2-bit to 4-rail) and dec1of4 (4-rail to 2-bit).
- One sub-module: qdi_sync_bus (parameterised width and depth flop chain), instantiated for C, D and Qe under the macro.

Test Plan:
- Reset, then WRITE with D=4'b1000 and C=3'b010 → Ce and De fall, inputs return neutral → reg=2'b11, Ce=De=1, no Q activity.
- READ (C=3'b001) with Qe=1 → Q=4'b1000. Drop Qe → Q=0 next cycle; Ce returns to 1.
- Sequence WRITE 2, READ, WRITE 0, READ, WRITE 1, READ → Q tokens 4'b0100, 4'b0001, 4'b0010; err=0.
- With reg=1, WRITE_READ with D=4'b0010 (value 1 written, 1 read), then WRITE_READ with D=4'b1000 → Q=4'b0010; a following READ gives Q=4'b1000.
- C=3'b011 (multi-hot) → err=1, Ce stays 1. Then a valid READ still completes normally, with err held at 1.
- RESET asserted while in OUT_DRV → Q=0, Ce=De=1 and reg=INIT_VAL, all asynchronously. With QDI_RESP_SYNC_EN, Ce falls exactly SYNC_STAGES+1 cycles after C goes valid.
